// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage divider: FSM states, handshake
// levels and the common bus widths.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    localparam logic RST_ENABLE           = 1'b1;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int unsigned REG_BUS        = 32;
    localparam int unsigned DOUBLE_REG_BUS = 64;
    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per
// cycle, result returned as {remainder, quotient} and held until start drops.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = REG_BUS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam logic [5:0] CNT_LAST = 6'(WIDTH);

    div_state_t         state, state_n;
    logic [5:0]         cnt, cnt_n;
    logic [2*WIDTH:0]   dividend, dividend_n;
    logic [WIDTH-1:0]   divisor, divisor_n;
    logic               sgn_q, sgn_n;
    logic               neg1_q, neg1_n;
    logic               neg2_q, neg2_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH-1:0]   quot, rem;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            sgn_q    <= 1'b0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            sgn_q    <= sgn_n;
            neg1_q   <= neg1_n;
            neg2_q   <= neg2_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        sgn_n      = sgn_q;
        neg1_n     = neg1_q;
        neg2_n     = neg2_q;
        result_n   = result_o;
        ready_n    = ready_o;

        // Trial subtraction of the divisor from the upper partial remainder.
        diff = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

        mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

        quot = dividend[WIDTH-1:0];
        rem  = dividend[2*WIDTH:WIDTH+1];
        if (sgn_q && (neg1_q ^ neg2_q)) begin
            quot = -quot;
        end
        if (sgn_q && neg1_q) begin
            rem = -rem;
        end

        unique case (state)
            DIV_FREE: begin
                result_n = '0;
                ready_n  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == ZERO_WORD[WIDTH-1:0]) begin
                        state_n = DIV_BY_ZERO;
                    end else begin
                        state_n    = DIV_ON;
                        cnt_n      = '0;
                        dividend_n = {{WIDTH{1'b0}}, mag1, 1'b0};
                        divisor_n  = mag2;
                        sgn_n      = signed_div_i;
                        neg1_n     = opdata1_i[WIDTH-1];
                        neg2_n     = opdata2_i[WIDTH-1];
                    end
                end
            end

            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                end else begin
                    state_n    = DIV_END;
                    dividend_n = '0;
                    result_n   = '0;
                    ready_n    = DIV_RESULT_READY;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_n  = DIV_FREE;
                    cnt_n    = '0;
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                end else if (cnt != CNT_LAST) begin
                    if (diff[WIDTH]) begin
                        dividend_n = {dividend[2*WIDTH-1:0], 1'b0};
                    end else begin
                        dividend_n = {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
                    end
                    cnt_n = cnt + 6'd1;
                end else begin
                    state_n  = DIV_END;
                    cnt_n    = '0;
                    result_n = {rem, quot};
                    ready_n  = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                    ready_n  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_n = DIV_FREE;
            end
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the radix-2 divider with a plain-arithmetic
// reference model checked on every cycle.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    logic        mon_en      = 1'b0;
    logic        allow_ready = 1'b0;
    logic [63:0] exp_result  = '0;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: native 64-bit arithmetic, C-style truncating division.
    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'h0, a};
            sb = {32'h0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ready_o !== 1'b1) begin
                    chk("idle_result_zero", {ready_o === 1'b0, result_o}, {1'b1, 64'h0});
                end else begin
                    chk("ready_allowed", {63'h0, ready_o}, {63'h0, allow_ready});
                    chk("model_result", result_o, exp_result);
                end
            end
        end
    end

    task automatic run_div(input string name, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] lit, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        exp_result   = model(s, a, b);
        allow_ready  = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = ~s;
            end
        end while (ready_o !== 1'b1 && lat < 100);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_result"}, result_o, lit);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_held"}, {63'h0, ready_o}, 64'h1);
        start_i = 1'b0;
        @(posedge clk); #1;
        allow_ready = 1'b0;
        chk({name, "_release"}, {63'h0, ready_o}, 64'h0);
        chk({name, "_release_result"}, result_o, 64'h0);
    endtask

    initial begin
        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'h0, ready_o}, 64'h0);
        chk("reset_result", result_o, 64'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Pin the model against hand-computed values.
        chk("model_100_7",   model(1'b0, 32'd100, 32'd7),               {32'd2, 32'd14});
        chk("model_m7_2",    model(1'b1, 32'hFFFFFFF9, 32'h2),           {32'hFFFFFFFF, 32'hFFFFFFFD});
        chk("model_7_m2",    model(1'b1, 32'h7, 32'hFFFFFFFE),           {32'h1, 32'hFFFFFFFD});
        chk("model_ovf",     model(1'b1, 32'h80000000, 32'hFFFFFFFF),    {32'h0, 32'h80000000});
        chk("model_umax_1",  model(1'b0, 32'hFFFFFFFF, 32'h1),           {32'h0, 32'hFFFFFFFF});

        run_div("u100_7",   1'b0, 32'd100, 32'd7,               {32'd2, 32'd14}, 34);
        run_div("s_m7_2",   1'b1, 32'hFFFFFFF9, 32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        run_div("s_7_m2",   1'b1, 32'h7, 32'hFFFFFFFE,          {32'h1, 32'hFFFFFFFD}, 34);
        run_div("u_dz",     1'b0, 32'd55, 32'd0,                64'h0, 2);
        run_div("s_dz",     1'b1, 32'hFFFFFFF0, 32'd0,          64'h0, 2);
        run_div("s_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF,   {32'h0, 32'h80000000}, 34);
        run_div("u_big",    1'b0, 32'hFFFFFFFF, 32'h00010000,   {32'h0000FFFF, 32'h0000FFFF}, 34);

        // Annul at cnt=10: no result may appear.
        @(posedge clk); #1;
        allow_ready = 1'b0;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        chk("annul_ready", {63'h0, ready_o}, 64'h0);
        chk("annul_result", result_o, 64'h0);
        run_div("u_after_annul", 1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 34);

        // Reset at cnt=20.
        @(posedge clk); #1;
        opdata1_i = 32'd77; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b0;
        chk("rst_mid_ready", {63'h0, ready_o}, 64'h0);
        chk("rst_mid_result", result_o, 64'h0);
        run_div("u_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34);

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
